// File: rtl/ps2_mouse_host_init_pkg.sv
// Shared types and PS/2 protocol constants for the mouse host init engine.
package mouse_pkg;

    typedef enum logic [3:0] {
        PWRUP,
        INHIBIT,
        REQ,
        TX,
        WAIT_IDLE,
        RX,
        FAIL_ATTEMPT,
        DONE,
        FAIL
    } state_t;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ENABLE = 8'hF4;

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_mouse_host_init_if.sv
// PS/2 line and status bundle between the host engine and its surroundings.
interface ps2_mouse_host_init_if;

    logic       restart;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_o;
    logic       ps2_data_o;
    logic       busy;
    logic       ready;
    logic       error;
    logic [1:0] retry_cnt;

    modport master (
        input  restart, ps2_clk_i, ps2_data_i,
        output ps2_clk_o, ps2_data_o, busy, ready, error, retry_cnt
    );

    modport slave (
        output restart, ps2_clk_i, ps2_data_i,
        input  ps2_clk_o, ps2_data_o, busy, ready, error, retry_cnt
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an idle-high PS/2 line plus a falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            s    <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= d;
            s    <= meta;
            prev <= s;
        end
    end

    assign fall = prev & ~s;

endmodule

// File: rtl/ps2_mouse_host_init.sv
// Sends the enable-reporting command to a PS/2 mouse and waits for its ACK.
module ps2_mouse_host_init
    import mouse_pkg::*;
#(
    parameter logic [15:0] POWERUP_CYCLES = 16'd50000,
    parameter logic [15:0] INHIBIT_CYCLES = 16'd6000,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000,
    parameter logic [7:0]  CMD_BYTE       = PS2_ENABLE,
    parameter int unsigned MAX_RETRY      = 3
) (
    input logic                   clk,
    input logic                   reset,
    ps2_mouse_host_init_if.master bus
);

    localparam logic [19:0] PWR_LAST   = {4'd0, POWERUP_CYCLES} - 20'd1;
    localparam logic [19:0] INH_LAST   = {4'd0, INHIBIT_CYCLES} - 20'd1;
    localparam logic [19:0] TO_LAST    = TIMEOUT_CYCLES - 20'd1;
    localparam logic [1:0]  RETRY_LAST = 2'(MAX_RETRY - 1);

    state_t      state;
    logic [19:0] timer;
    logic [3:0]  bit_cnt;
    logic [9:0]  tx_sr;
    logic [9:0]  rx_sr;
    logic        clk_s;
    logic        clk_fall;
    logic        data_s;
    logic        unused_data_fall;
    logic [10:0] rx_frame;
    logic        rx_ok;
    logic        timeout;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ps2_clk_i),
        .s     (clk_s),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ps2_data_i),
        .s     (data_s),
        .fall  (unused_data_fall)
    );

    // Frame as it will look once the 11th bit is shifted in.
    assign rx_frame = {data_s, rx_sr};
    assign rx_ok    = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1])
                    & (rx_frame[8:1] == PS2_ACK);
    assign timeout  = (timer == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= PWRUP;
            timer          <= '0;
            bit_cnt        <= '0;
            tx_sr          <= '1;
            rx_sr          <= '0;
            bus.ps2_clk_o  <= 1'b1;
            bus.ps2_data_o <= 1'b1;
            bus.busy       <= 1'b1;
            bus.ready      <= 1'b0;
            bus.error      <= 1'b0;
            bus.retry_cnt  <= '0;
        end else begin
            timer <= timer + 20'd1;
            unique case (state)
                PWRUP: begin
                    if (timer == PWR_LAST) begin
                        state         <= INHIBIT;
                        timer         <= '0;
                        bus.ps2_clk_o <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (timer == INH_LAST) begin
                        state          <= REQ;
                        timer          <= '0;
                        tx_sr          <= {1'b1, odd_par(CMD_BYTE), CMD_BYTE};
                        bus.ps2_clk_o  <= 1'b1;
                        bus.ps2_data_o <= 1'b0;
                    end
                end
                REQ: begin
                    state   <= TX;
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                TX: begin
                    if (clk_fall) begin
                        timer   <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            state          <= data_s ? FAIL_ATTEMPT : WAIT_IDLE;
                            bus.ps2_data_o <= 1'b1;
                        end else begin
                            bus.ps2_data_o <= tx_sr[0];
                            tx_sr          <= {1'b1, tx_sr[9:1]};
                        end
                    end else if (timeout) begin
                        state          <= FAIL_ATTEMPT;
                        timer          <= '0;
                        bus.ps2_data_o <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        state   <= RX;
                        timer   <= '0;
                        bit_cnt <= '0;
                    end else if (clk_fall) begin
                        timer <= '0;
                    end else if (timeout) begin
                        state <= FAIL_ATTEMPT;
                        timer <= '0;
                    end
                end
                RX: begin
                    if (clk_fall) begin
                        timer   <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            state <= rx_ok ? DONE : FAIL_ATTEMPT;
                            if (rx_ok) begin
                                bus.ready <= 1'b1;
                                bus.busy  <= 1'b0;
                            end
                        end else begin
                            rx_sr <= {data_s, rx_sr[9:1]};
                        end
                    end else if (timeout) begin
                        state <= FAIL_ATTEMPT;
                        timer <= '0;
                    end
                end
                FAIL_ATTEMPT: begin
                    timer         <= '0;
                    bus.retry_cnt <= bus.retry_cnt + 2'd1;
                    if (bus.retry_cnt == RETRY_LAST) begin
                        state     <= FAIL;
                        bus.busy  <= 1'b0;
                        bus.error <= 1'b1;
                    end else begin
                        state         <= INHIBIT;
                        bus.ps2_clk_o <= 1'b0;
                    end
                end
                DONE, FAIL: begin
                    if (bus.restart) begin
                        state         <= INHIBIT;
                        timer         <= '0;
                        bus.ready     <= 1'b0;
                        bus.error     <= 1'b0;
                        bus.retry_cnt <= '0;
                        bus.busy      <= 1'b1;
                        bus.ps2_clk_o <= 1'b0;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_host_init.sv
// Scoreboard bench: open-drain mouse model against the host init engine.
module tb_ps2_mouse_host_init;
    import mouse_pkg::*;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   inh_cnt  = 0;
    int   i0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb_q[$];

    // start 0, F4 LSB first, odd parity 0, stop 1
    localparam logic [10:0] F4_FRAME = 11'b1_0_11110100_0;
    // {clk_o, data_o, busy, ready, error, retry_cnt}
    localparam logic [6:0] ST_OK0   = 7'b11_0_1_0_00;
    localparam logic [6:0] ST_OK1   = 7'b11_0_1_0_01;
    localparam logic [6:0] ST_FAIL3 = 7'b11_0_0_1_11;

    ps2_mouse_host_init_if ifc ();

    ps2_mouse_host_init #(
        .POWERUP_CYCLES (16'd20),
        .INHIBIT_CYCLES (16'd30),
        .TIMEOUT_CYCLES (20'd400),
        .CMD_BYTE       (PS2_ENABLE),
        .MAX_RETRY      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    assign ifc.ps2_clk_i  = ifc.ps2_clk_o & dev_clk;
    assign ifc.ps2_data_i = ifc.ps2_data_o & dev_data;

    always #5 clk = ~clk;

    always @(negedge ifc.ps2_clk_o) inh_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [15:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 16'(sb_q.size()), 16'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device side of a host-to-device frame; ACKs after nedges == 11.
    task automatic dev_cmd(input int nedges);
        logic [10:0] obs;
        int          n;
        obs = '0;
        n   = 0;
        while (ifc.ps2_clk_o !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        while (!(ifc.ps2_clk_o === 1'b1 && ifc.ps2_data_o === 1'b0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("req_wait", 16'(n), 16'd0);
            return;
        end
        obs[0] = ifc.ps2_data_i;
        cyc(4);
        for (int k = 1; k <= 10 && k <= nedges; k++) begin
            dev_clk = 1'b0;
            cyc(8);
            obs[k]  = ifc.ps2_data_i;
            dev_clk = 1'b1;
            cyc(8);
        end
        if (nedges < 11) return;
        dev_data = 1'b0;
        cyc(4);
        dev_clk = 1'b0;
        cyc(8);
        dev_clk = 1'b1;
        cyc(4);
        dev_data = 1'b1;
        cyc(8);
        sb_pop(16'(obs));
    endtask

    task automatic dev_send(input logic [7:0] b, input bit good);
        logic [10:0] f;
        f = {1'b1, good ? ~^b : ^b, b, 1'b0};
        cyc(20);
        for (int i = 0; i < 11; i++) begin
            dev_data = f[i];
            cyc(4);
            dev_clk = 1'b0;
            cyc(8);
            dev_clk = 1'b1;
            cyc(4);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ifc.busy !== 1'b0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        sb_pop(16'({ifc.ps2_clk_o, ifc.ps2_data_o, ifc.busy,
                    ifc.ready, ifc.error, ifc.retry_cnt}));
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        ifc.restart = 1'b1;
        @(negedge clk);
        ifc.restart = 1'b0;
    endtask

    initial begin
        ifc.restart = 1'b0;
        reset = 1'b1;
        cyc(3);
        chk("rst_clk_o", 16'(ifc.ps2_clk_o), 16'd1);
        chk("rst_data_o", 16'(ifc.ps2_data_o), 16'd1);
        chk("rst_busy", 16'(ifc.busy), 16'd1);
        chk("rst_ready", 16'(ifc.ready), 16'd0);
        chk("rst_error", 16'(ifc.error), 16'd0);
        chk("rst_retry", 16'(ifc.retry_cnt), 16'd0);
        reset = 1'b0;

        sb_push("nom_frame", 16'(F4_FRAME));
        sb_push("nom_status", 16'(ST_OK0));
        dev_cmd(11);
        dev_send(PS2_ACK, 1'b1);
        wait_done();

        sb_push("rsnd_frame1", 16'(F4_FRAME));
        sb_push("rsnd_frame2", 16'(F4_FRAME));
        sb_push("rsnd_status", 16'(ST_OK1));
        i0 = inh_cnt;
        pulse_restart();
        dev_cmd(11);
        dev_send(PS2_RESEND, 1'b1);
        dev_cmd(11);
        dev_send(PS2_ACK, 1'b1);
        wait_done();
        chk("rsnd_inhibits", 16'(inh_cnt - i0), 16'd2);

        for (int a = 0; a < 3; a++) sb_push("par_frame", 16'(F4_FRAME));
        sb_push("par_status", 16'(ST_FAIL3));
        pulse_restart();
        repeat (3) begin
            dev_cmd(11);
            dev_send(PS2_ACK, 1'b0);
        end
        wait_done();

        sb_push("rfail_frame", 16'(F4_FRAME));
        sb_push("rfail_status", 16'(ST_OK0));
        pulse_restart();
        chk("rfail_inhibit", 16'(ifc.ps2_clk_o), 16'd0);
        chk("rfail_err_clr", 16'(ifc.error), 16'd0);
        dev_cmd(11);
        dev_send(PS2_ACK, 1'b1);
        wait_done();

        sb_push("silent_status", 16'(ST_FAIL3));
        pulse_restart();
        wait_done();

        pulse_restart();
        dev_cmd(4);
        chk("mid_data_low", 16'(ifc.ps2_data_o), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_clk_o", 16'(ifc.ps2_clk_o), 16'd1);
        chk("mid_data_o", 16'(ifc.ps2_data_o), 16'd1);
        chk("mid_busy", 16'(ifc.busy), 16'd1);
        chk("mid_state", 16'(dut.state), 16'(PWRUP));
        @(negedge clk);
        reset = 1'b0;
        sb_push("mid_frame", 16'(F4_FRAME));
        sb_push("mid_status", 16'(ST_OK0));
        dev_cmd(11);
        dev_send(PS2_ACK, 1'b1);
        wait_done();

        chk("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
